// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised valid/ready pipeline register with a two-entry
// skid buffer and synchronous flush. ready_o is decoded from state flops only,
// so it never combinationally depends on ready_i or valid_i.
// Optional performance counters are built when PIPE_STAGE_PERF_EN is defined;
// otherwise stall_cnt_o/beat_cnt_o are tied to zero.
module pipe_stage_reg #(
  parameter int                 DATA_W  = 32,
  parameter logic [DATA_W-1:0]  NOP_VAL = '0,
  parameter int                 CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  beat_cnt_o
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] skd_q, skd_d;
  logic              in_fire, out_fire;

  assign valid_o  = (state_q != EMPTY);
  assign ready_o  = (state_q != FULL);
  assign occ_o    = state_q;
  assign data_o   = out_q;
  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;

  // Next-state and datapath selection; flush overrides normal traffic.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skd_d   = skd_q;
    if (flush_i) begin
      state_d = EMPTY;
      out_d   = NOP_VAL;
      skd_d   = NOP_VAL;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = BUSY;
            out_d   = data_i;
          end
        end
        BUSY: begin
          if (in_fire && !out_fire) begin
            state_d = FULL;
            skd_d   = data_i;
          end else if (!in_fire && out_fire) begin
            state_d = EMPTY;
            out_d   = NOP_VAL;
          end else if (in_fire && out_fire) begin
            out_d   = data_i;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d = BUSY;
            out_d   = skd_q;
            skd_d   = NOP_VAL;
          end
        end
        default: begin
          state_d = EMPTY;
          out_d   = NOP_VAL;
          skd_d   = NOP_VAL;
        end
      endcase
    end
  end

  // State and payload registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      out_q   <= NOP_VAL;
      skd_q   <= NOP_VAL;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skd_q   <= skd_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] beat_q, beat_d;

  // Saturating counters; flush deliberately leaves them alone.
  always_comb begin
    stall_d = stall_q;
    beat_d  = beat_q;
    if (valid_o && !ready_i && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + CNT_W'(1);
    if (out_fire && (beat_q != {CNT_W{1'b1}}))
      beat_d = beat_q + CNT_W'(1);
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
      beat_q  <= '0;
    end else begin
      stall_q <= stall_d;
      beat_q  <= beat_d;
    end
  end

  assign stall_cnt_o = stall_q;
  assign beat_cnt_o  = beat_q;
`else
  assign stall_cnt_o = '0;
  assign beat_cnt_o  = '0;
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline register stage for the CPU datapath; successor to the fixed per-stage pipeline registers.
- Carries one DATA_W-bit payload (packed control + data fields of any stage) with a valid/ready handshake.
- Two-entry skid buffer, so ready_o has no combinational path from ready_i. Stall is expressed as ready_i low.
- Synchronous flush inserts a bubble whose payload is NOP_VAL.

Parameters:
DATA_W, 32, payload width in bits (>=1)
NOP_VAL, 0 (DATA_W bits), payload driven on data_o when stage empty/flushed
CNT_W, 16, width of performance counters (optional feature only)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous active-high reset
valid_i  input  1  upstream beat valid
ready_o  output  1  stage can accept a beat
data_i  input  DATA_W  upstream payload
flush_i  input  1  synchronous flush, discards all held beats
valid_o  output  1  downstream beat valid
ready_i  input  1  downstream accepts (low = stall)
data_o  output  DATA_W  downstream payload
occ_o  output  2  occupancy, 0..2
stall_cnt_o  output  CNT_W  stall cycle count (optional feature)
beat_cnt_o  output  CNT_W  delivered beat count (optional feature)

Behaviour:
- Handshakes:
  - in_fire = valid_i & ready_o
  - out_fire = valid_o & ready_i
- Storage:
  - Main register OUT drives data_o.
  - Skid register SKD is used only in FULL.
- Signal decode:
  - valid_o = (state != EMPTY)
  - ready_o = (state != FULL)
  - occ_o = 0/1/2 for EMPTY/BUSY/FULL
  - All three are decoded from state flops only; ready_i and valid_i never reach ready_o combinationally.
- State transitions, priority rst_i > flush_i > normal:
  - EMPTY: in_fire -> BUSY, OUT<=data_i; else stay.
  - BUSY: in_fire & !out_fire -> FULL, SKD<=data_i. !in_fire & out_fire -> EMPTY, OUT<=NOP_VAL. in_fire & out_fire -> BUSY, OUT<=data_i. Neither -> hold.
  - FULL: out_fire -> BUSY, OUT<=SKD, SKD<=NOP_VAL; else hold. No input accepted (ready_o=0).
- Latency and throughput:
  - Latency: beat accepted at edge N appears on data_o/valid_o after edge N (one cycle).
  - Throughput: one beat per cycle while ready_i=1.
- Ordering: beats are delivered in acceptance order; no loss or duplication outside flush/reset.
- Stall: while ready_i=0, data_o and valid_o are held stable. The stage absorbs at most one more beat (BUSY->FULL), then drops ready_o.
- Flush (flush_i=1, rst_i=0):
  - Next state EMPTY; OUT<=NOP_VAL; SKD<=NOP_VAL.
  - Any in_fire in the same cycle is discarded.
  - An out_fire in the same cycle still counts as delivered to downstream.
  - Counters are not affected.
- Reset (rst_i=1):
  - State EMPTY, OUT=SKD=NOP_VAL, counters 0.
  - Any beat offered during reset is discarded.
  - Reset mid-operation drops all held beats.
- Output values after reset: valid_o=0, ready_o=1, occ_o=0, data_o=NOP_VAL, counters 0.
- When EMPTY, data_o always equals NOP_VAL.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- When defined:
  - stall_cnt_o increments each cycle with valid_o=1 & ready_i=0.
  - beat_cnt_o increments on each out_fire.
  - Both saturate at all-ones and are cleared only by rst_i.
- When undefined: both ports exist but are tied to 0; no counter flops are built.

Test Plan:
- Reset, then DATA_W=32, NOP_VAL=0, valid_i=1 with data 0x11,0x22,0x33 on consecutive cycles, ready_i=1 -> data_o 0x11,0x22,0x33 one cycle later, valid_o high 3 cycles, occ_o=1 throughout, ready_o=1.
- Push 0xA1 then 0xA2 with ready_i=0 -> occ_o 1 then 2, ready_o=0 after second edge, data_o=0xA1 held. Raise ready_i -> 0xA1 then 0xA2 delivered, occ_o 2->1->0, data_o returns to 0.
- FULL (0xB1,0xB2 held), flush_i=1 one cycle with valid_i=1 data 0xB3 -> next cycle valid_o=0, occ_o=0, data_o=0, ready_o=1; 0xB3 never appears.
- BUSY holding 0xC1, rst_i=1 one cycle with valid_i=1 data 0xC2 -> valid_o=0, data_o=NOP_VAL; 0xC1/0xC2 never appear. Repeat with NOP_VAL=0x13 -> data_o=0x13.
- Random valid_i/ready_i for 10,000 cycles, no flush -> output sequence equals input sequence exactly; ready_o never changes in the same cycle as a ready_i change.
- PIPE_STAGE_PERF_EN defined, CNT_W=4 -> 5 stall cycles give stall_cnt_o=5. 20 delivered beats give beat_cnt_o=15 (saturated). flush_i leaves both counters unchanged. rst_i clears both to 0.
